axis_uart_tx: RTL and testbench

AXIS_UART_TX -- requirements
Module: axis_uart_tx

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_baud_cnt.sv | 30 +++
 rtl/axis_uart_tx.sv | 126 ++++++++++++
 tb/tb_axis_uart_tx.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmitter.
// UART_TX_PARITY_EN adds the PARITY state to the FSM encoding.
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 868;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-time counter: counts CLKS_PER_BIT cycles, restarts on clr, flags the last cycle of a bit.
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic bit_end
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign bit_end = (cnt == CNT_MAX);

endmodule

// File: rtl/axis_uart_tx.sv
// UART transmitter draining a FIFO one character at a time, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module axis_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int WIDTH        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    input  logic             fifo_wr_acc,
    input  logic [WIDTH-1:0] fifo_dout,
    input  logic             fifo_dout_last,
    output logic             fifo_rd_en,
    output logic             tx,
    output logic             busy,
    output logic             frame_done
);

    localparam int IDX_W = $clog2(WIDTH) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_t           state, state_next;
    logic [WIDTH-1:0] shift_q;
    logic             last_q;
    logic [IDX_W-1:0] bit_idx;
    logic             bit_end;
    logic             cnt_clr;
`ifdef UART_TX_PARITY_EN
    logic             parity_q;
`endif

    // Restarting the counter on every state change keeps each bit exactly CLKS_PER_BIT long.
    assign cnt_clr = (state_next != state);

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr),
        .bit_end(bit_end)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shift_q  <= '0;
            last_q   <= 1'b0;
            bit_idx  <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state <= state_next;
            case (state)
                LOAD: begin
                    shift_q  <= fifo_dout;
                    last_q   <= fifo_dout_last;
                    bit_idx  <= '0;
`ifdef UART_TX_PARITY_EN
                    parity_q <= ^fifo_dout;
`endif
                end
                DATA: begin
                    if (bit_end) begin
                        shift_q <= shift_q >> 1;
                        bit_idx <= bit_idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // The FETCH read completes only when no write lands in the same cycle, so retry until it does.
    always_comb begin
        state_next = state;
        fifo_rd_en = 1'b0;
        tx         = 1'b1;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) state_next = FETCH;
            end
            FETCH: begin
                fifo_rd_en = 1'b1;
                if (!fifo_wr_acc) state_next = LOAD;
            end
            LOAD: begin
                state_next = START;
            end
            START: begin
                tx = 1'b0;
                if (bit_end) state_next = DATA;
            end
            DATA: begin
                tx = shift_q[0];
                if (bit_end && bit_idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx = parity_q;
                if (bit_end) state_next = STOP;
            end
`endif
            STOP: begin
                if (bit_end) begin
                    frame_done = last_q;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_axis_uart_tx.sv
// Directed self-checking bench for axis_uart_tx with CLKS_PER_BIT=4, WIDTH=8.
// Honours UART_TX_PARITY_EN to expect the extra parity bit.
`ifdef UART_TX_PARITY_EN
`define FRM(d, p) {1'b1, p, d, 1'b0}
`else
`define FRM(d, p) {1'b1, d, 1'b0}
`endif

module tb_axis_uart_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fifo_empty;
    logic       fifo_wr_acc = 1'b0;
    logic [7:0] fifo_dout = 8'h00;
    logic       fifo_dout_last = 1'b0;
    logic       fifo_rd_en;
    logic       tx;
    logic       busy;
    logic       frame_done;

    logic [7:0] mem_data [0:15];
    logic       mem_last [0:15];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    int         reads = 0;
    int         rd_cycles = 0;
    int         empty_rd = 0;
    int         compared = 0;
    int         mismatched = 0;

    axis_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .WIDTH       (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fifo_empty    (fifo_empty),
        .fifo_wr_acc   (fifo_wr_acc),
        .fifo_dout     (fifo_dout),
        .fifo_dout_last(fifo_dout_last),
        .fifo_rd_en    (fifo_rd_en),
        .tx            (tx),
        .busy          (busy),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (wr_ptr == rd_ptr);

    // FIFO model: a read is performed only when no write is accepted in the same cycle.
    always @(posedge clk) begin
        if (fifo_rd_en) rd_cycles <= rd_cycles + 1;
        if (fifo_rd_en && fifo_empty) empty_rd <= empty_rd + 1;
        if (fifo_rd_en && !fifo_wr_acc && !fifo_empty) begin
            fifo_dout      <= mem_data[rd_ptr % 16];
            fifo_dout_last <= mem_last[rd_ptr % 16];
            rd_ptr         <= rd_ptr + 1;
            reads          <= reads + 1;
        end
    end

    task automatic applyStimulus(input logic [7:0] d, input logic l);
        mem_data[wr_ptr % 16] = d;
        mem_last[wr_ptr % 16] = l;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Walks one character cycle by cycle, starting from the negedge before IDLE sees a queued entry.
    task automatic run_char(input logic [FRAME_BITS-1:0] frame, input logic l,
                            input bit retry, input string tag);
        int off;
        int idx;
        int r0;
        int c0;
        off = retry ? 1 : 0;
        r0  = reads;
        c0  = rd_cycles;
        for (int k = 1; k <= FRAME_CYC + 3 + off; k++) begin
            @(negedge clk);
            idx = k - 3 - off;
            checkOutput($sformatf("%s rd_en k=%0d", tag, k), fifo_rd_en, (k <= 1 + off) ? 1 : 0);
            if (idx >= 0 && idx < FRAME_CYC)
                checkOutput($sformatf("%s tx k=%0d", tag, k), tx, frame[idx / CPB]);
            else
                checkOutput($sformatf("%s tx k=%0d", tag, k), tx, 1);
            checkOutput($sformatf("%s busy k=%0d", tag, k), busy, (idx < FRAME_CYC) ? 1 : 0);
            checkOutput($sformatf("%s frame_done k=%0d", tag, k), frame_done,
                        (l && idx == FRAME_CYC - 1) ? 1 : 0);
            fifo_wr_acc = retry && (k == 1);
        end
        checkOutput($sformatf("%s reads", tag), reads - r0, 1);
        checkOutput($sformatf("%s rd_cycles", tag), rd_cycles - c0, 1 + off);
    endtask

    int bad_rd;
    int bad_tx;
    int bad_busy;
    int r_before;

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset tx", tx, 1);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset rd_en", fifo_rd_en, 0);
        checkOutput("reset frame_done", frame_done, 0);
        rst = 1'b0;

        // Empty FIFO for 100 cycles
        bad_rd = 0; bad_tx = 0; bad_busy = 0;
        repeat (100) begin
            @(negedge clk);
            if (fifo_rd_en !== 1'b0) bad_rd++;
            if (tx !== 1'b1) bad_tx++;
            if (busy !== 1'b0) bad_busy++;
        end
        checkOutput("idle rd_en cycles", bad_rd, 0);
        checkOutput("idle tx low cycles", bad_tx, 0);
        checkOutput("idle busy cycles", bad_busy, 0);

        // Single characters, not last then last
        applyStimulus(8'hA5, 1'b0);
        run_char(`FRM(8'hA5, 1'b0), 1'b0, 1'b0, "A5");
        applyStimulus(8'h3C, 1'b1);
        run_char(`FRM(8'h3C, 1'b0), 1'b1, 1'b0, "3C");

        // Write accepted during the first FETCH cycle forces a retry
        applyStimulus(8'h5A, 1'b1);
        run_char(`FRM(8'h5A, 1'b0), 1'b1, 1'b1, "5A retry");

        // Reset during data bit 3 aborts the character without re-reading it
        applyStimulus(8'hA5, 1'b0);
        r_before = reads;
        repeat (3 + 4 * CPB) @(negedge clk);
        checkOutput("abort pre tx bit3", tx, 0);
        checkOutput("abort pre busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort tx", tx, 1);
        checkOutput("abort busy", busy, 0);
        checkOutput("abort rd_en", fifo_rd_en, 0);
        checkOutput("abort frame_done", frame_done, 0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("abort stays idle", busy, 0);
        checkOutput("abort reads", reads - r_before, 1);

        // Back-to-back characters with a 3-cycle gap
        applyStimulus(8'hFF, 1'b0);
        applyStimulus(8'h00, 1'b1);
        run_char(`FRM(8'hFF, 1'b0), 1'b0, 1'b0, "FF b2b");
        run_char(`FRM(8'h00, 1'b0), 1'b1, 1'b0, "00 b2b");

        // Odd and even weight bytes for the parity build
        applyStimulus(8'h07, 1'b0);
        run_char(`FRM(8'h07, 1'b1), 1'b0, 1'b0, "07");
        applyStimulus(8'h03, 1'b1);
        run_char(`FRM(8'h03, 1'b0), 1'b1, 1'b0, "03");

        checkOutput("rd_en while empty", empty_rd, 0);
        checkOutput("fifo drained", wr_ptr - rd_ptr, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
